jregister: RTL and testbench



---
 rtl/jregister.sv | 29 ++
 tb/tb_jregister.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/jregister.sv
// Byte-wide storage register for the jcscpu datapath: captures bis on set,
// drives the stored value onto bos only while enabled (zeros otherwise).
module jregister #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] bis,
    input  logic             s,
    input  logic             e,
    output logic [WIDTH-1:0] bos
);

    logic [WIDTH-1:0] r_q;

    // Reset outranks set, so a load issued during reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= RESET_VALUE;
        end else if (s) begin
            r_q <= bis;
        end
    end

    // Drives hard zeros when disabled so that several registers can share a wired-OR bus.
    assign bos = e ? r_q : '0;

endmodule

// File: tb/tb_jregister.sv
// Directed bench for jregister: a vector table for single-edge behaviour, plus
// short hand-written sequences for enable timing, bis stability and wired-OR sharing.
module tb_jregister;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n, s, e;
    logic [W-1:0] bis, bos;
    logic         b_reset_n, b_s, b_e;
    logic [W-1:0] b_bis, b_bos;
    logic [W-1:0] bus;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jregister #(.WIDTH(W)) u_a (
        .clk(clk), .reset_n(reset_n), .bis(bis), .s(s), .e(e), .bos(bos)
    );

    jregister #(.WIDTH(W), .RESET_VALUE(8'hC3)) u_b (
        .clk(clk), .reset_n(b_reset_n), .bis(b_bis), .s(b_s), .e(b_e), .bos(b_bos)
    );

    assign bus = bos | b_bos;

    typedef struct {
        logic         rst_n;
        logic         s;
        logic         e;
        logic [W-1:0] bis;
        logic         chk_pre;
        logic [W-1:0] exp_pre;
        logic [W-1:0] exp_post;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int idx);
        @(negedge clk);
        reset_n = vecs[idx].rst_n;
        s       = vecs[idx].s;
        e       = vecs[idx].e;
        bis     = vecs[idx].bis;
        #1;
        if (vecs[idx].chk_pre) check($sformatf("vec%0d_pre", idx), bos, vecs[idx].exp_pre);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_post", idx), bos, vecs[idx].exp_post);
    endtask

    initial begin
        //          rst  s     e     bis    chk   pre    post
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h00}; // reset beats set
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 8'h00, 8'h14}; // load
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h14, 8'h14}; // hold x3
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h14, 8'h14};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h14, 8'h14};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h16, 1'b1, 8'h14, 8'h16};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00}; // disabled
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h16, 8'h16}; // q untouched by e
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h16, 8'h00}; // plain reset
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h2A, 1'b1, 8'h00, 8'h2A}; // no bypass
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 8'h2A, 8'h01}; // continuous set
        vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 8'h01, 8'h02};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 8'h02, 8'h03};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 8'h03, 8'h03};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 8'h03, 8'h00}; // reset during load
        vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 8'h00, 8'h00}; // load while disabled
        vecs[16] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C, 8'h3C};

        reset_n = 1'b0; s = 1'b0; e = 1'b0; bis = '0;
        b_reset_n = 1'b0; b_s = 1'b0; b_e = 1'b1; b_bis = '0;

        // Second instance carries a non-zero reset value.
        @(posedge clk);
        #1;
        check("b_reset_value", b_bos, 8'hC3);
        @(negedge clk);
        b_reset_n = 1'b1;
        b_e       = 1'b0;
        #1;
        check("b_disabled_zero", b_bos, 8'h00);

        for (int i = 0; i < 17; i++) apply_vec(i);

        // Enable toggled mid-cycle with no edge between; q=3C, s=0.
        @(negedge clk);
        e = 1'b0;
        #1;
        check("e_off_immediate", bos, 8'h00);
        #1;
        e = 1'b1;
        #1;
        check("e_on_immediate", bos, 8'h3C);

        // bis wiggled between edges with s low, then a load where bis settles before the edge.
        bis = 8'h99;
        #1;
        bis = 8'h66;
        @(posedge clk);
        #1;
        check("bis_ignored_s0", bos, 8'h3C);
        s = 1'b1;
        bis = 8'hE1;
        #1;
        bis = 8'h7E;
        @(posedge clk);
        #1;
        check("bis_at_edge", bos, 8'h7E);
        @(negedge clk);
        s = 1'b0;

        // Wired-OR sharing: a holds 0F, b holds F0.
        @(negedge clk);
        s = 1'b1; bis = 8'h0F; e = 1'b0;
        b_s = 1'b1; b_bis = 8'hF0; b_e = 1'b0;
        @(posedge clk);
        #1;
        s = 1'b0; b_s = 1'b0;
        #1;
        check("bus_none", bus, 8'h00);
        e = 1'b1;
        #1;
        check("bus_a", bus, 8'h0F);
        e = 1'b0; b_e = 1'b1;
        #1;
        check("bus_b", bus, 8'hF0);
        e = 1'b1;
        #1;
        check("bus_both", bus, 8'hFF);
        e = 1'b0; b_e = 1'b0;
        #1;
        check("bus_none_again", bus, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
